// File: rtl/timer_counter_pkg.sv
// rtl/timer_counter_pkg.sv - register offsets, CTRL fields, mode codes and FSM states for the countdown timer
package timer_counter_pkg;

    localparam logic [31:0] TIMER_BASE_ADDR = 32'h0000_7F00;

    localparam logic [1:0] OFF_CTRL   = 2'b00;
    localparam logic [1:0] OFF_PRESET = 2'b01;
    localparam logic [1:0] OFF_COUNT  = 2'b10;
    localparam logic [1:0] OFF_RSVD   = 2'b11;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IM = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CNT  = 2'b10,
        ST_INT  = 2'b11
    } state_e;

    // Reserved modes 2'b1x fall back to one-shot behaviour.
    function automatic logic is_periodic(input logic [3:0] ctrl);
        return ctrl[2:1] == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - bridge-side register bus and interrupt line of the timer
interface timer_counter_if;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    logic [31:0] rd;
    logic        irq;

    modport master (output addr, output wd, output we, input rd, input irq);
    modport slave  (input addr, input wd, input we, output rd, output irq);
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped countdown timer with one-shot/periodic interrupt
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE_ADDR
) (
    input  logic             clk,
    input  logic             reset,
    timer_counter_if.slave   bus
);

    logic [3:0]  ctrl_q,     ctrl_d;
    logic [31:0] preset_q,   preset_d;
    logic [31:0] count_q,    count_d;
    logic        irq_flag_q, irq_flag_d;
    state_e      state_q,    state_d;

    logic [1:0]  sel;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        unmask;
    logic        unused_bits;

    assign sel         = bus.addr[3:2];
    assign wr_ctrl     = bus.we && (sel == OFF_CTRL);
    assign wr_preset   = bus.we && (sel == OFF_PRESET);
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], BASE_ADDR};

    // Raising IM from 0 to 1 acknowledges nothing: it re-exposes a pending flag.
    assign unmask = wr_ctrl && bus.wd[CTRL_IM] && !ctrl_q[CTRL_IM];

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        state_d    = state_q;

        if (wr_preset) begin
            preset_d = bus.wd;
        end
        if ((wr_ctrl || wr_preset) && !unmask) begin
            irq_flag_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (count_q == 32'd0) begin
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                if (is_periodic(ctrl_q)) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A software CTRL write takes precedence over the one-shot EN clear.
        if (wr_ctrl) begin
            ctrl_d = bus.wd[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        bus.rd = 32'd0;
        case (sel)
            OFF_CTRL:   bus.rd = {28'd0, ctrl_q};
            OFF_PRESET: bus.rd = preset_q;
            OFF_COUNT:  bus.rd = count_q;
            default:    bus.rd = 32'd0;
        endcase
    end

    assign bus.irq = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter
module tb_timer_counter;
    import timer_counter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    timer_counter_if bus ();

    timer_counter #(.BASE_ADDR(32'h0000_7F00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        bus.addr = 32'h0000_7F00 + {28'd0, off, 2'b00};
        bus.wd   = data;
        bus.we   = 1'b1;
        tick();
        bus.we   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        bus.addr = 32'h0000_7F00 + {28'd0, off, 2'b00};
        #1;
        check(tag, bus.rd, exp);
    endtask

    task automatic irq_chk(input string tag, input logic exp);
        check(tag, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        bus.addr = 32'h0000_7F00;
        bus.wd   = 32'd0;
        bus.we   = 1'b0;

        // Reset
        tick();
        tick();
        reset = 1'b0;
        rd_chk("rst_ctrl", OFF_CTRL, 32'd0);
        rd_chk("rst_preset", OFF_PRESET, 32'd0);
        rd_chk("rst_count", OFF_COUNT, 32'd0);
        irq_chk("rst_irq", 1'b0);

        // One-shot, PRESET=5
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            rd_chk($sformatf("os_count_%0d", i), OFF_COUNT, 32'(5 - i));
            irq_chk($sformatf("os_irq_low_%0d", i), 1'b0);
            tick();
        end
        irq_chk("os_irq_t8", 1'b1);
        rd_chk("os_count_t8", OFF_COUNT, 32'd0);
        tick();
        rd_chk("os_ctrl_en_cleared", OFF_CTRL, 32'h8);
        irq_chk("os_irq_held", 1'b1);
        tick();
        tick();
        irq_chk("os_irq_held2", 1'b1);
        wr(OFF_PRESET, 32'd5);
        irq_chk("os_irq_ack", 1'b0);

        // Periodic, PRESET=3: period 7, 1-cycle pulse
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'hB);
        for (int c = 1; c <= 21; c++) begin
            tick();
            irq_chk($sformatf("per_irq_c%0d", c), (c >= 6) && (((c - 6) % 7) == 0));
        end
        wr(OFF_CTRL, 32'h0);
        tick();
        tick();
        tick();
        irq_chk("per_stopped", 1'b0);

        // Pause and mask
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h9);
        for (int i = 0; i < 7; i++) tick();
        rd_chk("pause_count5", OFF_COUNT, 32'd5);
        wr(OFF_CTRL, 32'h8);
        rd_chk("pause_count4", OFF_COUNT, 32'd4);
        tick();
        tick();
        rd_chk("pause_frozen", OFF_COUNT, 32'd4);
        irq_chk("pause_irq", 1'b0);
        wr(OFF_CTRL, 32'h1);
        tick();
        tick();
        rd_chk("mask_reload", OFF_COUNT, 32'd10);
        for (int i = 0; i < 11; i++) tick();
        rd_chk("mask_count0", OFF_COUNT, 32'd0);
        irq_chk("mask_irq_hidden", 1'b0);
        tick();
        rd_chk("mask_ctrl_en_cleared", OFF_CTRL, 32'h0);
        irq_chk("mask_irq_hidden2", 1'b0);
        wr(OFF_CTRL, 32'h8);
        irq_chk("mask_irq_exposed", 1'b1);
        wr(OFF_CTRL, 32'h0);
        irq_chk("mask_irq_ack", 1'b0);

        // PRESET=0, COUNT write, reserved read
        wr(OFF_PRESET, 32'd0);
        wr(OFF_CTRL, 32'h9);
        tick();
        tick();
        irq_chk("p0_irq_t2", 1'b0);
        tick();
        irq_chk("p0_irq_t3", 1'b1);
        tick();
        rd_chk("p0_no_underflow", OFF_COUNT, 32'd0);
        wr(OFF_COUNT, 32'h55);
        rd_chk("count_wr_ignored", OFF_COUNT, 32'd0);
        irq_chk("count_wr_keeps_irq", 1'b1);
        wr(OFF_RSVD, 32'hFFFF_FFFF);
        rd_chk("rsvd_read", OFF_RSVD, 32'd0);
        rd_chk("rsvd_wr_ignored_ctrl", OFF_CTRL, 32'h8);

        // Reset mid-count
        wr(OFF_PRESET, 32'd20);
        wr(OFF_CTRL, 32'h9);
        for (int i = 0; i < 5; i++) tick();
        rd_chk("midrst_count17", OFF_COUNT, 32'd17);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd_chk("midrst_ctrl", OFF_CTRL, 32'd0);
        rd_chk("midrst_preset", OFF_PRESET, 32'd0);
        rd_chk("midrst_count", OFF_COUNT, 32'd0);
        irq_chk("midrst_irq", 1'b0);
        tick();
        tick();
        rd_chk("midrst_idle_count", OFF_COUNT, 32'd0);

        // Collision: CTRL write on the flag-set edge, then on the INT edge
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'h9);
        for (int i = 0; i < 4; i++) tick();
        rd_chk("col_count0", OFF_COUNT, 32'd0);
        irq_chk("col_irq_pre", 1'b0);
        wr(OFF_CTRL, 32'h9);
        irq_chk("col_set_wins", 1'b1);
        rd_chk("col_ctrl", OFF_CTRL, 32'h9);
        wr(OFF_CTRL, 32'h9);
        rd_chk("int_ctrl_override", OFF_CTRL, 32'h9);
        irq_chk("int_wr_clears", 1'b0);
        for (int i = 0; i < 4; i++) tick();
        irq_chk("restart_irq_low", 1'b0);
        tick();
        irq_chk("restart_irq", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
